// File: rtl/irq_watchdog_gen.sv
`timescale 1ns/1ps
// irq_watchdog_gen
//   Periodic interrupt generator combined with a watchdog that pulses an
//   internal CPU reset.
//   Two-state controller: HOLD keeps the CPU in reset for RST_PULSE clocks,
//   then RUN lets the periodic IRQ counter and the watchdog counter run.
//   A watchdog bite in RUN returns the block to HOLD.
//
// Ports
//   clk_3       in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   wdclr       in   watchdog clear strobe (synchronous)
//   wddis_n     in   low suspends watchdog counting
//   irqclr      in   interrupt acknowledge
//   reset_int_n out  internal CPU reset, active-low, registered
//   irq_n       out  interrupt request, active-low, registered
//   irq_overrun out  sticky: a tick arrived while irq_n was already low
//   bite_count  out  saturating count of watchdog bites since reset_n
module irq_watchdog_gen #(
   parameter int unsigned IRQ_PERIOD = 8192,
   parameter int unsigned WD_TIMEOUT = 24576,
   parameter int unsigned RST_PULSE  = 16,
   parameter bit          WD_ENABLE  = 1'b1
) (
   input  logic       clk_3,
   input  logic       reset_n,
   input  logic       wdclr,
   input  logic       wddis_n,
   input  logic       irqclr,
   output logic       reset_int_n,
   output logic       irq_n,
   output logic       irq_overrun,
   output logic [7:0] bite_count
);

   // Counter widths; a single-clock pulse still needs a 1-bit counter.
   localparam int unsigned IW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
   localparam int unsigned WW = (WD_TIMEOUT > 1) ? $clog2(WD_TIMEOUT) : 1;
   localparam int unsigned PW = (RST_PULSE  > 1) ? $clog2(RST_PULSE)  : 1;

   localparam logic [IW-1:0] IRQ_LAST   = IW'(IRQ_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST    = WW'(WD_TIMEOUT - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

   typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [IW-1:0]   irq_cnt_q, irq_cnt_d;
   logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
   logic            irq_n_q, irq_n_d;
   logic            overrun_q, overrun_d;
   logic [7:0]      bite_cnt_q, bite_cnt_d;

   logic in_run;
   logic tick;
   logic wd_count_en;
   logic bite;
   logic active;

   assign in_run      = (state_q == RUN);
   assign tick        = in_run && (irq_cnt_q == IRQ_LAST);
   assign wd_count_en = in_run && WD_ENABLE && wddis_n;
   // wdclr outranks a bite landing on the same clock.
   assign bite        = wd_count_en && !wdclr && (wd_cnt_q == WD_LAST);
   // Counters only live while staying in RUN; entering HOLD clears them on
   // the same edge so nothing from the old run leaks into the reset pulse.
   assign active      = in_run && !bite;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_3 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         HOLD:    if (pulse_cnt_q == PULSE_LAST) state_d = RUN;
         RUN:     if (bite) state_d = HOLD;
         default: state_d = HOLD;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // RUN is encoded as 1, so the reset output is the state flop itself.
   always_comb begin
      reset_int_n = (state_q == RUN);
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      pulse_cnt_d = '0;
      if (state_q == HOLD && state_d == HOLD) begin
         pulse_cnt_d = pulse_cnt_q + 1'b1;
      end

      irq_cnt_d = '0;
      irq_n_d   = 1'b1;
      overrun_d = 1'b0;
      wd_cnt_d  = '0;
      if (active) begin
         irq_cnt_d = tick ? '0 : irq_cnt_q + 1'b1;

         // A tick beats a simultaneous acknowledge.
         if (tick)        irq_n_d = 1'b0;
         else if (irqclr) irq_n_d = 1'b1;
         else             irq_n_d = irq_n_q;

         if (tick && !irq_n_q && !irqclr) overrun_d = 1'b1;
         else if (irqclr && !tick)        overrun_d = 1'b0;
         else                             overrun_d = overrun_q;

         if (wdclr)            wd_cnt_d = '0;
         else if (wd_count_en) wd_cnt_d = wd_cnt_q + 1'b1;
         else                  wd_cnt_d = wd_cnt_q;
      end

      bite_cnt_d = bite_cnt_q;
      if (bite && bite_cnt_q != 8'hFF) begin
         bite_cnt_d = bite_cnt_q + 8'd1;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_3 or negedge reset_n) begin
      if (!reset_n) begin
         pulse_cnt_q <= '0;
         irq_cnt_q   <= '0;
         wd_cnt_q    <= '0;
         irq_n_q     <= 1'b1;
         overrun_q   <= 1'b0;
         bite_cnt_q  <= 8'd0;
      end else begin
         pulse_cnt_q <= pulse_cnt_d;
         irq_cnt_q   <= irq_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         irq_n_q     <= irq_n_d;
         overrun_q   <= overrun_d;
         bite_cnt_q  <= bite_cnt_d;
      end
   end

   assign irq_n       = irq_n_q;
   assign irq_overrun = overrun_q;
   assign bite_count  = bite_cnt_q;

endmodule

// File: tb/tb_irq_watchdog_gen.sv
`timescale 1ns/1ps
// Bench for irq_watchdog_gen: a scaled main instance plus a minimal
// WD_ENABLE=0 instance. Expected output edges are queued when stimulus is
// driven and matched against observed edges on the falling clock.
module tb_irq_watchdog_gen;

   localparam int P = 12;   // IRQ_PERIOD
   localparam int T = 50;   // WD_TIMEOUT
   localparam int R = 5;    // RST_PULSE

   logic       clk = 1'b0;
   logic       reset_n, wdclr, wddis_n, irqclr;
   logic       reset_int_n, irq_n, irq_overrun;
   logic [7:0] bite_count;

   logic       rst2_n, wdclr2, wddis2_n, irqclr2;
   logic       reset_int2_n, irq2_n, irq_overrun2;
   logic [7:0] bite_count2;

   always #5 clk = ~clk;

   irq_watchdog_gen #(
      .IRQ_PERIOD(P), .WD_TIMEOUT(T), .RST_PULSE(R), .WD_ENABLE(1'b1)
   ) dut (
      .clk_3(clk), .reset_n(reset_n), .wdclr(wdclr), .wddis_n(wddis_n),
      .irqclr(irqclr), .reset_int_n(reset_int_n), .irq_n(irq_n),
      .irq_overrun(irq_overrun), .bite_count(bite_count)
   );

   irq_watchdog_gen #(
      .IRQ_PERIOD(2), .WD_TIMEOUT(2), .RST_PULSE(1), .WD_ENABLE(1'b0)
   ) dut_nowd (
      .clk_3(clk), .reset_n(rst2_n), .wdclr(wdclr2), .wddis_n(wddis2_n),
      .irqclr(irqclr2), .reset_int_n(reset_int2_n), .irq_n(irq2_n),
      .irq_overrun(irq_overrun2), .bite_count(bite_count2)
   );

   int checks_cnt = 0;
   int fail_cnt   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks_cnt++;
      if (obs != exp) begin
         fail_cnt++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int   cyc;
      logic val;
   } edge_t;

   edge_t rst_q[$];
   edge_t irq_q[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_prev = 1'b0;
   logic irq_prev = 1'b1;
   bit   rst2_armed = 1'b0;
   bit   rst2_low_seen = 1'b0;

   always @(negedge clk) begin
      edge_t e;
      if (reset_int_n !== rst_prev) begin
         if (rst_q.size() == 0) begin
            check("rst_unexpected_edge_at", cyc, -1);
         end else begin
            e = rst_q.pop_front();
            check("rst_edge_cycle", cyc, e.cyc);
            check("rst_edge_value", reset_int_n, e.val);
         end
      end
      if (irq_n !== irq_prev) begin
         if (irq_q.size() == 0) begin
            check("irq_unexpected_edge_at", cyc, -1);
         end else begin
            e = irq_q.pop_front();
            check("irq_edge_cycle", cyc, e.cyc);
            check("irq_edge_value", irq_n, e.val);
         end
      end
      if (rst2_armed && reset_int2_n == 1'b0) rst2_low_seen = 1'b1;
      rst_prev = reset_int_n;
      irq_prev = irq_n;
   end

   // ---------------- stimulus bookkeeping ----------------
   int run_start  = -1;
   int next_tick  = -1;
   int bite_at    = -1;
   int exp_bites  = 0;
   int bites_seen = 0;
   bit auto_ack   = 1'b0;
   bit ack_pending = 1'b0;

   // One clock: retire a pending acknowledge, then queue the edges the
   // current clock is expected to produce (bite or serviced IRQ tick).
   task automatic step();
      @(posedge clk);
      #1;
      if (ack_pending) begin
         irqclr = 1'b0;
         ack_pending = 1'b0;
      end
      if (cyc == bite_at) begin
         rst_q.push_back('{bite_at, 1'b0});
         rst_q.push_back('{bite_at + R, 1'b1});
         bites_seen++;
         if (exp_bites < 255) exp_bites++;
         check("bite_count", bite_count, exp_bites);
         run_start = bite_at + R;
         next_tick = run_start + P;
         bite_at   = run_start + T;
      end else if (auto_ack && cyc == next_tick) begin
         irq_q.push_back('{cyc, 1'b0});
         irq_q.push_back('{cyc + 1, 1'b1});
         irqclr = 1'b1;
         ack_pending = 1'b1;
         next_tick += P;
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // wdclr sampled on edge c; the next bite is T clocks later.
   task automatic wd_clear_at(input int c);
      run_to(c - 1);
      wdclr = 1'b1;
      bite_at = c + T;
      step();
      wdclr = 1'b0;
   endtask

   task automatic release_reset();
      reset_n   = 1'b1;
      run_start = cyc + R;
      rst_q.push_back('{run_start, 1'b1});
      next_tick = run_start + P;
      bite_at   = wddis_n ? run_start + T : -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int rel, t1, b;
      reset_n = 1'b1; rst2_n = 1'b1;
      wdclr = 1'b0; wddis_n = 1'b0; irqclr = 1'b0;
      wdclr2 = 1'b0; wddis2_n = 1'b1; irqclr2 = 1'b0;
      #1;
      reset_n = 1'b0; rst2_n = 1'b0;

      // Power-up reset state
      repeat (5) step();
      check("rst_reset_int_n", reset_int_n, 0);
      check("rst_irq_n", irq_n, 1);
      check("rst_overrun", irq_overrun, 0);
      check("rst_bite_count", bite_count, 0);
      check("rst2_reset_int_n", reset_int2_n, 0);

      // Release; watchdog suspended (wddis_n=0), IRQs serviced.
      rel = cyc;
      release_reset();
      rst2_n = 1'b1;
      auto_ack = 1'b1;

      // Minimal build: 1-clock pulse, IRQ every 2 clocks, no watchdog
      run_to(rel + 1);
      check("nowd_run_after_1", reset_int2_n, 1);
      rst2_armed = 1'b1;
      run_to(rel + 2);
      check("nowd_irq_not_yet", irq2_n, 1);
      run_to(rel + 3);
      check("nowd_irq_tick", irq2_n, 0);
      run_to(rel + 5);
      check("nowd_overrun_set", irq_overrun2, 1);
      irqclr2 = 1'b1;
      step();
      irqclr2 = 1'b0;
      check("nowd_irq_cleared", irq2_n, 1);
      check("nowd_overrun_cleared", irq_overrun2, 0);

      // IRQ period with acknowledge; well past T with counting suspended
      run_to(run_start + 10 * P + 2);
      check("period_no_overrun", irq_overrun, 0);
      check("disabled_no_bite", bite_count, 0);

      // Overrun, then tick/irqclr tie, then plain irqclr
      auto_ack = 1'b0;
      t1 = next_tick;
      irq_q.push_back('{t1, 1'b0});
      run_to(t1);
      check("ovr_first_tick", irq_n, 0);
      check("ovr_not_yet", irq_overrun, 0);
      run_to(t1 + P);
      check("ovr_set", irq_overrun, 1);
      run_to(t1 + 2 * P - 1);
      irqclr = 1'b1;
      step();
      check("tie_tick_wins", irq_n, 0);
      check("tie_overrun_kept", irq_overrun, 1);
      irq_q.push_back('{t1 + 2 * P + 1, 1'b1});
      step();
      irqclr = 1'b0;
      check("clr_irq_n", irq_n, 1);
      check("clr_overrun", irq_overrun, 0);
      next_tick = t1 + 3 * P;
      auto_ack = 1'b1;

      // Enable the watchdog with a clear; first bite T clocks later
      wddis_n = 1'b1;
      wd_clear_at(cyc + 1);
      b = bite_at;
      run_to(b + R + 1);
      check("bite_then_run", reset_int_n, 1);
      check("bite_count_one", bite_count, 1);

      // Periodic clears inside the timeout, then one on the would-bite clock
      for (int i = 0; i < 5; i++) wd_clear_at(next_tick + 2 * P + 3);
      wd_clear_at(bite_at);
      check("clear_beats_bite", bite_count, 1);

      // Repeated bites until saturation
      while (bites_seen < 301 && cyc < 80000) step();
      check("bite_loop_done", bites_seen, 301);
      check("bite_saturated", bite_count, 255);

      // Reset mid-pulse: no extra edge, count cleared, full pulse after release
      step();
      step();
      reset_n = 1'b0;
      rst_q.delete();
      bite_at = -1; next_tick = -1; exp_bites = 0;
      #1;
      check("midpulse_bite_cleared", bite_count, 0);
      check("midpulse_reset_low", reset_int_n, 0);
      repeat (3) step();
      release_reset();

      // Reset mid-count in RUN
      run_to(run_start + P + 5);
      rst_q.push_back('{cyc, 1'b0});
      reset_n = 1'b0;
      bite_at = -1; next_tick = -1;
      #1;
      check("midcount_reset_low", reset_int_n, 0);
      check("midcount_irq_high", irq_n, 1);
      repeat (2) step();
      release_reset();
      b = bite_at;
      run_to(b + R + 2);
      check("bite_after_rerun", bite_count, 1);

      run_to(cyc + 5);
      check("rst_queue_drained", rst_q.size(), 0);
      check("irq_queue_drained", irq_q.size(), 0);
      check("nowd_never_bit", rst2_low_seen, 0);
      check("nowd_bite_count", bite_count2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
